// File: rtl/wb_uart_fifo_port.sv
// wb_uart_fifo_port: Wishbone slave bridging CPU register accesses to tty byte streams
// through a pair of first-word-fall-through FIFOs.
module wb_uart_fifo_port #(
    parameter int DATA_WIDTH   = 32,
    parameter int SELECT_WIDTH = 4,
    parameter int FIFO_LOG2    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3:0]              adr_i,
    input  logic [DATA_WIDTH-1:0]   dat_i,
    output logic [DATA_WIDTH-1:0]   dat_o,
    input  logic                    we_i,
    input  logic [SELECT_WIDTH-1:0] sel_i,
    input  logic                    stb_i,
    input  logic                    cyc_i,
    output logic                    ack_o,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic                    rx_ready
);
    localparam int DEPTH = 1 << FIFO_LOG2;
    localparam int CW    = FIFO_LOG2 + 1;

    logic [7:0]           tx_mem [DEPTH];
    logic [7:0]           rx_mem [DEPTH];
    logic [FIFO_LOG2-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
    logic [CW-1:0]        tx_cnt, rx_cnt;
    logic                 tx_ovf;
    logic                 tx_full, tx_empty, rx_full, rx_nonempty;
    logic                 req, is_data, is_stat, data_wr;
    logic                 tx_push, tx_pop, rx_push, rx_pop, ovf_set, ovf_clr;
    logic [31:0]          status;
    logic [DATA_WIDTH-1:0] rd_val;
    logic                 unused;

    assign unused      = ^{sel_i[SELECT_WIDTH-1:1], adr_i[1:0], dat_i[DATA_WIDTH-1:8]};
    assign tx_full     = tx_cnt == CW'(DEPTH);
    assign tx_empty    = tx_cnt == '0;
    assign rx_full     = rx_cnt == CW'(DEPTH);
    assign rx_nonempty = rx_cnt != '0;
    assign tx_valid    = ~tx_empty;
    assign tx_data     = tx_mem[tx_rp];
    assign rx_ready    = ~rx_full;

    // ack_o in the request term limits the bus to one access per two cycles
    assign req     = stb_i & cyc_i & ~ack_o;
    assign is_data = adr_i[3:2] == 2'd0;
    assign is_stat = adr_i[3:2] == 2'd1;
    assign data_wr = req & we_i & is_data & sel_i[0];
    assign tx_push = data_wr & ~tx_full;
    assign ovf_set = data_wr & tx_full;
    assign ovf_clr = req & we_i & is_stat & sel_i[0] & dat_i[3];
    assign rx_pop  = req & ~we_i & is_data & sel_i[0] & rx_nonempty;
    assign tx_pop  = tx_valid & tx_ready;
    assign rx_push = rx_valid & rx_ready;

    assign status = {8'b0, 8'(tx_cnt), 8'(rx_cnt), 3'b0, rx_full, tx_ovf, tx_empty, tx_full, rx_nonempty};

    always_comb begin
        rd_val = we_i ? '0 :
                 is_data ? (rx_nonempty ? DATA_WIDTH'({23'b0, 1'b1, rx_mem[rx_rp]}) : '0) :
                 is_stat ? DATA_WIDTH'(status) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_o  <= 1'b0;
            dat_o  <= '0;
            tx_wp  <= '0;
            tx_rp  <= '0;
            rx_wp  <= '0;
            rx_rp  <= '0;
            tx_cnt <= '0;
            rx_cnt <= '0;
            tx_ovf <= 1'b0;
        end else begin
            ack_o  <= req;
            dat_o  <= req ? rd_val : '0;
            tx_wp  <= tx_wp + FIFO_LOG2'(tx_push);
            tx_rp  <= tx_rp + FIFO_LOG2'(tx_pop);
            rx_wp  <= rx_wp + FIFO_LOG2'(rx_push);
            rx_rp  <= rx_rp + FIFO_LOG2'(rx_pop);
            tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
            rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
            tx_ovf <= ovf_set | (tx_ovf & ~ovf_clr);
        end
    end

    // storage needs no reset; pointers and counts define what is valid
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp] <= dat_i[7:0];
        if (rx_push) rx_mem[rx_wp] <= rx_data;
    end
endmodule

// File: tb/tb_wb_uart_fifo_port.sv
// tb_wb_uart_fifo_port: directed and randomized checks of wb_uart_fifo_port against
// a queue-based model of the register map and stream FIFOs.
module tb_wb_uart_fifo_port;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  adr = '0;
    logic [31:0] dat_w = '0;
    logic [31:0] dat_o;
    logic        we = 1'b0;
    logic [3:0]  sel = '0;
    logic        stb = 1'b0;
    logic        cyc = 1'b0;
    logic        ack_o;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;

    logic [7:0]  txq[$];
    logic [7:0]  rxq[$];
    logic        m_ovf = 1'b0;
    logic        m_ack = 1'b0;
    logic [31:0] rd;
    int          compared = 0;
    int          mismatched = 0;

    always #5 clk = ~clk;

    wb_uart_fifo_port dut (
        .clk(clk), .rst(rst), .adr_i(adr), .dat_i(dat_w), .dat_o(dat_o), .we_i(we),
        .sel_i(sel), .stb_i(stb), .cyc_i(cyc), .ack_o(ack_o),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = '0;
        s[0] = rxq.size() != 0;
        s[1] = txq.size() == DEPTH;
        s[2] = txq.size() == 0;
        s[3] = m_ovf;
        s[4] = rxq.size() == DEPTH;
        s[15:8] = 8'(rxq.size());
        s[23:16] = 8'(txq.size());
        return s;
    endfunction

    // one clock edge: predict from pre-edge inputs and model, then compare after the edge
    task automatic step();
        logic req, rdacc, txp, rxp, txw, rxpop, ovs, ovc;
        logic [31:0] rv;
        logic [7:0] rb, wb;
        req = stb && cyc && !m_ack;
        rdacc = req && !we;
        txp = txq.size() > 0 && tx_ready;
        rxp = rx_valid && rxq.size() < DEPTH;
        rb = rx_data;
        wb = dat_w[7:0];
        rv = '0;
        txw = 0; rxpop = 0; ovs = 0; ovc = 0;
        if (rdacc) begin
            if (adr[3:2] == 2'd0 && rxq.size() > 0) rv = {23'b0, 1'b1, rxq[0]};
            if (adr[3:2] == 2'd1) rv = m_status();
            rxpop = adr[3:2] == 2'd0 && sel[0] && rxq.size() > 0;
        end else if (req && sel[0]) begin
            if (adr[3:2] == 2'd0) begin
                if (txq.size() == DEPTH) ovs = 1; else txw = 1;
            end else if (adr[3:2] == 2'd1 && dat_w[3]) ovc = 1;
        end
        @(posedge clk);
        #1;
        if (txp) void'(txq.pop_front());
        if (txw) txq.push_back(wb);
        if (rxpop) void'(rxq.pop_front());
        if (rxp) rxq.push_back(rb);
        if (ovs) m_ovf = 1'b1;
        else if (ovc) m_ovf = 1'b0;
        m_ack = req;
        chk("ack", {31'b0, ack_o}, {31'b0, m_ack});
        if (rdacc) chk("rdata", dat_o, rv);
        else if (!req) chk("dat_idle", dat_o, 32'h0);
        chk("tx_valid", {31'b0, tx_valid}, {31'b0, txq.size() != 0});
        if (txq.size() > 0) chk("tx_data", {24'b0, tx_data}, {24'b0, txq[0]});
        chk("rx_ready", {31'b0, rx_ready}, {31'b0, rxq.size() < DEPTH});
    endtask

    task automatic access(input logic w, input logic [3:0] a, input logic [31:0] d);
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_w = d; sel = 4'h1;
        step();
        rd = dat_o;
        stb = 1'b0; cyc = 1'b0;
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        txq.delete();
        rxq.delete();
        m_ovf = 1'b0;
        m_ack = 1'b0;
        chk("rst_ack", {31'b0, ack_o}, 32'h0);
        chk("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
        chk("rst_rx_ready", {31'b0, rx_ready}, 32'h1);
        chk("rst_dat", dat_o, 32'h0);
        stb = 1'b0; cyc = 1'b0;
        #2 rst = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset();
        access(0, 4'h4, 0);
        chk("t1_status", rd, 32'h4);

        tx_ready = 1'b0;
        access(1, 4'h0, 32'h41);
        access(1, 4'h0, 32'h42);
        access(1, 4'h0, 32'h43);
        access(0, 4'h4, 0);
        chk("t2_txcnt", {24'b0, rd[23:16]}, 32'd3);
        tx_ready = 1'b1;
        chk("t2_b0", {24'b0, tx_data}, 32'h41);
        step();
        chk("t2_b1", {24'b0, tx_data}, 32'h42);
        step();
        chk("t2_b2", {24'b0, tx_data}, 32'h43);
        step();
        chk("t2_empty", {31'b0, tx_valid}, 32'h0);

        tx_ready = 1'b0;
        for (int i = 0; i < 17; i++) access(1, 4'h0, 32'h60 + i);
        access(0, 4'h4, 0);
        chk("t3_ovf", {31'b0, rd[3]}, 32'h1);
        chk("t3_full", {31'b0, rd[1]}, 32'h1);
        chk("t3_txcnt", {24'b0, rd[23:16]}, 32'd16);
        chk("t3_status", rd, 32'h0010000A);
        access(1, 4'h4, 32'h8);
        access(0, 4'h4, 0);
        chk("t3_w1c", {31'b0, rd[3]}, 32'h0);
        tx_ready = 1'b1;
        chk("t3_head", {24'b0, tx_data}, 32'h60);
        repeat (16) step();
        tx_ready = 1'b0;

        rx_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rx_data = 8'(i);
            step();
        end
        rx_valid = 1'b0;
        chk("t4_rx_ready", {31'b0, rx_ready}, 32'h0);
        for (int i = 0; i < 16; i++) begin
            access(0, 4'h0, 0);
            chk("t4_rd", rd, 32'h100 + i);
        end
        access(0, 4'h0, 0);
        chk("t4_rd_empty", rd, 32'h0);

        rx_valid = 1'b1; rx_data = 8'h5A;
        stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = 4'h0; sel = 4'h1;
        step();
        rx_valid = 1'b0; stb = 1'b0; cyc = 1'b0;
        chk("t5_rd_race", dat_o, 32'h0);
        step();
        access(0, 4'h0, 0);
        chk("t5_rd_next", rd, 32'h15A);

        for (int i = 0; i < 5; i++) access(1, 4'h0, 32'hA0 + i);
        stb = 1'b1; cyc = 1'b1; we = 1'b1; adr = 4'h0; dat_w = 32'h99; sel = 4'h1;
        step();
        chk("t6_ack_before", {31'b0, ack_o}, 32'h1);
        do_reset();
        access(0, 4'h4, 0);
        chk("t6_txcnt", {24'b0, rd[23:16]}, 32'h0);
        chk("t6_status", rd, 32'h4);

        for (int n = 0; n < 4000; n++) begin
            stb = $urandom_range(0, 2) != 0;
            cyc = $urandom_range(0, 7) != 0;
            we = 1'(($urandom));
            adr = {($urandom_range(0, 5) < 4) ? 1'b0 : 1'b1, 1'($urandom), 2'($urandom)};
            sel = 4'($urandom);
            dat_w = $urandom;
            tx_ready = ((n / 500) % 2 == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            rx_valid = ((n / 700) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            rx_data = 8'($urandom);
            step();
        end
        stb = 1'b0; cyc = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
